subckt_stim_driver: RTL and testbench
=====================================

// Module: subckt_stim_driver
// PURPOSE
//  Driving end of the 5-input Nt-node subcircuit interface: generates pseudo-random 5-bit
//  stimulus vectors for a subcircuit under test and compacts its 1-bit response into a MISR.
//  Sits beside each extracted subcircuit in the trojan-detection bench; golden vs. suspect
//  signatures are compared off-block.
// PARAMETERS
//  LFSR_W     16      width of stimulus LFSR and response MISR (fixed poly, see package)
//  VEC_W      5       stimulus vector width (vec_out = lfsr[VEC_W-1:0])
//  CNT_W      16      width of num_vectors / vec_count
//  DUT_LAT    2       cycles from vector applied to its response valid on resp_in
// PORTS
//  I1470_clk    in   1       clock, all state on rising edge
//  I1477_rst    in   1       synchronous active-high reset
//  start        in   1       pulse: begin run (sampled only in IDLE)
//  abort        in   1       return to IDLE next cycle, done stays 0
//  seed         in   LFSR_W  LFSR seed, sampled with start
//  num_vectors  in   CNT_W   vectors to apply; 0 = run completes immediately
//  vec_out      out  VEC_W   stimulus to subcircuit inputs
//  vec_valid    out  1       vec_out is a live vector this cycle
//  resp_in      in   1       subcircuit output
//  signature    out  LFSR_W  MISR contents; stable while done=1
//  vec_count    out  CNT_W   vectors applied so far
//  busy         out  1       state != IDLE && state != DONE
//  done         out  1       high in DONE until next start or reset
// BEHAVIOUR
//  Reset (sync, I1477_rst=1 at edge): state=IDLE, lfsr=0, misr=0, vec_count=0, vec_out=0,
//   vec_valid=0, busy=0, done=0, signature=0. Reset beats start/abort same cycle.
//  FSM: IDLE -start-> RUN (num_vectors!=0) | DONE (num_vectors==0, signature=0).
//   RUN: each cycle vec_valid=1, vec_out=lfsr[VEC_W-1:0], lfsr steps, vec_count++;
//    cycle applying vector number num_vectors -> DRAIN.
//   DRAIN: vec_valid=0, vec_out holds last vector; lasts exactly DUT_LAT cycles -> DONE
//    (DUT_LAT=0: RUN -> DONE directly).
//   DONE: outputs frozen; start -> RUN/DONE as from IDLE (counters/MISR cleared).
//   abort in RUN/DRAIN/DONE -> IDLE next cycle, done=0, signature retains last misr.
//   start while busy: ignored.
//  LFSR: Fibonacci, taps 16,14,13,11; next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
//   seed==0 at start loads 16'hACE1 (lock-up avoidance). First vector = seed[4:0].
//  MISR: cleared at start; next = {m[14:0], m[15]^m[13]^m[12]^m[10]^resp_in}.
//   Compacts resp_in only on cycles where a delayed vec_valid (DUT_LAT-deep shift reg
//   of vec_valid) is 1 -> exactly num_vectors compaction cycles per run.
//  vec_count saturates at all-ones; num_vectors compared before increment.
//  Latency: start edge -> first vec_valid=1 next cycle; done rises DUT_LAT cycles after
//   last vec_valid cycle + 1.
// STRUCTURE
//  Package subckt_tb_pkg: LFSR_POLY/taps, LFSR_ZERO_SUB=16'hACE1, state enum
//   {IDLE,RUN,DRAIN,DONE}.
//  Sub-module lfsr_step (comb: state, in_bit -> next state), instanced twice
//   (stimulus with in_bit=0, MISR with resp_in). FSM, counters, valid delay line in top.
// TESTING
//  1 seed=16'h0001, num=5, resp_in=0 -> vec_out 01,02,04,08,10; vec_count=5; signature=0.
//  2 seed=16'h0000, num=1 -> vec_out=5'h01 (0xACE1[4:0]); done after 1+DUT_LAT+1 cycles.
//  3 resp_in=1 constant, seed=1, num=3 -> signature=16'h0007; done=1, busy=0.
//  4 num=0 + start -> DONE next cycle, vec_valid never 1, signature=0.
//  5 abort in RUN after 2 vectors -> IDLE next cycle, done=0, vec_valid=0; start in RUN ignored.
//  6 I1477_rst asserted mid-DRAIN with start high -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/subckt_stim_driver_pkg.sv
// Shared constants and types for the subcircuit stimulus driver:
// the 16-bit LFSR/MISR polynomial, lock-up seed substitute and FSM states.
package subckt_tb_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps at bit positions 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_ZERO_SUB : seed;
    endfunction

endpackage

// File: rtl/subckt_stim_driver_if.sv
// Run-control, stimulus and response signals between the stimulus driver
// (master) and the environment that launches runs and hosts the subcircuit (slave).
interface subckt_stim_driver_if
    import subckt_tb_pkg::*;
#(
    parameter int VEC_W = 5,
    parameter int CNT_W = 16
);
    logic              start;
    logic              abort;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0]  num_vectors;
    logic [VEC_W-1:0]  vec_out;
    logic              vec_valid;
    logic              resp_in;
    logic [LFSR_W-1:0] signature;
    logic [CNT_W-1:0]  vec_count;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, seed, num_vectors, resp_in,
        output vec_out, vec_valid, signature, vec_count, busy, done
    );

    modport slave (
        output start, abort, seed, num_vectors, resp_in,
        input  vec_out, vec_valid, signature, vec_count, busy, done
    );

endinterface

// File: rtl/subckt_stim_driver_lfsr_step.sv
// One step of the fixed 16-bit Fibonacci shift register, with an extra input
// bit folded into the feedback (0 for stimulus generation, resp_in for the MISR).
module lfsr_step
    import subckt_tb_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    input  logic              i_bit,
    output logic [LFSR_W-1:0] o_next
);
    logic w_fb;

    assign w_fb   = (^(i_state & LFSR_TAPS)) ^ i_bit;
    assign o_next = {i_state[LFSR_W-2:0], w_fb};

endmodule

// File: rtl/subckt_stim_driver.sv
// Applies num_vectors pseudo-random vectors to a subcircuit and compacts its
// delayed 1-bit response into a MISR signature.
module subckt_stim_driver
    import subckt_tb_pkg::*;
#(
    parameter int VEC_W   = 5,
    parameter int CNT_W   = 16,
    parameter int DUT_LAT = 2
)
(
    input  logic                 I1470_clk,
    input  logic                 I1477_rst,
    subckt_stim_driver_if.master bus
);
    localparam int                DRAIN_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_e             r_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  r_misr;
    logic [CNT_W-1:0]   r_vec_count;
    logic [CNT_W-1:0]   r_num;
    logic [VEC_W-1:0]   r_vec_out;
    logic               r_vec_valid;
    logic [DRAIN_W-1:0] r_drain_cnt;

    logic [LFSR_W-1:0]  w_seed;
    logic [LFSR_W-1:0]  w_step_in;
    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [LFSR_W-1:0]  w_misr_next;
    logic               w_vv_dly;
    logic               w_comp_en;
    logic               w_kill;

    assign w_seed    = seed_fix(bus.seed);
    // Outside RUN the stepper pre-computes the state after the first vector.
    assign w_step_in = (r_state == RUN) ? r_lfsr : w_seed;
    assign w_kill    = bus.abort && (r_state != IDLE);
    assign w_comp_en = w_vv_dly && ((r_state == RUN) || (r_state == DRAIN));

    lfsr_step u_stim_step (
        .i_state (w_step_in),
        .i_bit   (1'b0),
        .o_next  (w_lfsr_next)
    );

    lfsr_step u_misr_step (
        .i_state (r_misr),
        .i_bit   (bus.resp_in),
        .o_next  (w_misr_next)
    );

    // vec_valid delayed by the subcircuit latency marks cycles whose resp_in is live.
    if (DUT_LAT == 0) begin : g_no_dly
        assign w_vv_dly = r_vec_valid;
    end else begin : g_dly
        logic [DUT_LAT-1:0] r_vv_dly;

        // NOTE: this shift line is control state, not a data buffer, so it is
        // reset and flushed on abort to keep stale valids out of the next run.
        always_ff @(posedge I1470_clk) begin
            if (I1477_rst || w_kill) begin
                r_vv_dly <= '0;
            end else begin
                r_vv_dly <= (r_vv_dly << 1) | DUT_LAT'(r_vec_valid);
            end
        end

        assign w_vv_dly = r_vv_dly[DUT_LAT-1];
    end

    // NOTE: all state here uses non-blocking assignment so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_state     <= IDLE;
            r_lfsr      <= '0;
            r_misr      <= '0;
            r_vec_count <= '0;
            r_num       <= '0;
            r_vec_out   <= '0;
            r_vec_valid <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            if (w_comp_en) begin
                r_misr <= w_misr_next;
            end

            if (w_kill) begin
                r_state     <= IDLE;
                r_vec_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            r_misr <= '0;
                            r_num  <= bus.num_vectors;
                            if (bus.num_vectors == '0) begin
                                r_state     <= DONE;
                                r_vec_count <= '0;
                            end else begin
                                r_state     <= RUN;
                                r_vec_valid <= 1'b1;
                                r_vec_out   <= w_seed[VEC_W-1:0];
                                r_lfsr      <= w_lfsr_next;
                                r_vec_count <= CNT_W'(1);
                            end
                        end
                    end
                    RUN: begin
                        if (r_vec_count == r_num) begin
                            r_vec_valid <= 1'b0;
                            if (DUT_LAT == 0) begin
                                r_state <= DONE;
                            end else begin
                                r_state     <= DRAIN;
                                r_drain_cnt <= DRAIN_LAST;
                            end
                        end else begin
                            r_vec_out <= r_lfsr[VEC_W-1:0];
                            r_lfsr    <= w_lfsr_next;
                            if (r_vec_count != CNT_MAX) begin
                                r_vec_count <= r_vec_count + CNT_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (r_drain_cnt == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.vec_out   = r_vec_out;
    assign bus.vec_valid = r_vec_valid;
    assign bus.signature = r_misr;
    assign bus.vec_count = r_vec_count;
    assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_subckt_stim_driver.sv
// Bench for subckt_stim_driver: directed and randomized runs checked against an
// arithmetic model of the stimulus sequence and MISR signature.
module tb_subckt_stim_driver;

    localparam int VEC_W   = 5;
    localparam int CNT_W   = 16;
    localparam int DUT_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Subcircuit model state: 0 = resp 0, 1 = resp 1, 2 = parity function of the vector.
    int         resp_mode = 0;
    logic [4:0] resp_mask = '0;
    logic       resp_inv  = 1'b0;
    logic [5:0] h0 = '0, h1 = '0, h2 = '0;

    subckt_stim_driver_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) bus ();

    subckt_stim_driver #(.VEC_W(VEC_W), .CNT_W(CNT_W), .DUT_LAT(DUT_LAT)) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic resp_fn(input logic [4:0] v);
        return (^(v & resp_mask)) ^ resp_inv;
    endfunction

    function automatic logic resp_for(input logic [4:0] v);
        if (resp_mode == 0) return 1'b0;
        if (resp_mode == 1) return 1'b1;
        return resp_fn(v);
    endfunction

    // The subcircuit answers each vector DUT_LAT cycles later; other cycles carry noise.
    always @(posedge clk) begin
        #1;
        h2 = h1;
        h1 = h0;
        h0 = {bus.vec_valid, bus.vec_out};
        if (resp_mode == 0)      bus.resp_in = 1'b0;
        else if (resp_mode == 1) bus.resp_in = 1'b1;
        else                     bus.resp_in = h2[5] ? resp_fn(h2[4:0]) : 1'($urandom);
    end

    function automatic logic [15:0] ref_step(input logic [15:0] l, input logic b);
        int unsigned v;
        int unsigned fb;
        v  = l;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10) ^ b) & 1;
        return 16'(((v << 1) | fb) & 32'hFFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " vec_out"},   32'(bus.vec_out),   32'h0);
        check({tag, " vec_valid"}, 32'(bus.vec_valid), 32'h0);
        check({tag, " busy"},      32'(bus.busy),      32'h0);
        check({tag, " done"},      32'(bus.done),      32'h0);
        check({tag, " signature"}, 32'(bus.signature), 32'h0);
        check({tag, " vec_count"}, 32'(bus.vec_count), 32'h0);
    endtask

    // Expected vector list: lfsr[4:0] of successive LFSR states from the (fixed) seed.
    task automatic build_model(input logic [15:0] seed, input int num,
                               output logic [4:0] vecs[$], output logic [15:0] sig);
        logic [15:0] l;
        l   = (seed == 16'h0) ? 16'hACE1 : seed;
        sig = 16'h0;
        vecs.delete();
        for (int i = 0; i < num; i++) begin
            vecs.push_back(l[4:0]);
            l = ref_step(l, 1'b0);
        end
        foreach (vecs[i]) sig = ref_step(sig, resp_for(vecs[i]));
    endtask

    task automatic do_run(input logic [15:0] seed, input int num, input string tag,
                          output logic [15:0] sig_exp);
        logic [4:0] vecs[$];
        int         k;
        int         n;
        build_model(seed, num, vecs, sig_exp);
        bus.seed        = seed;
        bus.num_vectors = 16'(num);
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (bus.vec_valid === 1'b1 && k < num + 4) begin
            if (k < num) check($sformatf("%s vec%0d", tag, k), 32'(bus.vec_out), 32'(vecs[k]));
            k++;
            tick();
        end
        check({tag, " vector count"}, 32'(k), 32'(num));
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " drain latency"}, 32'(n), 32'(DUT_LAT));
        check({tag, " signature"}, 32'(bus.signature), 32'(sig_exp));
        check({tag, " vec_count"}, 32'(bus.vec_count), 32'(num));
        check({tag, " busy"},      32'(bus.busy),      32'h0);
    endtask

    initial begin
        logic [15:0] sig;
        logic [4:0]  vecs[$];
        logic [15:0] dummy;

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.seed        = '0;
        bus.num_vectors = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Walking-one stimulus, silent subcircuit.
        resp_mode = 0;
        do_run(16'h0001, 5, "t1", sig);
        check("t1 signature zero", 32'(bus.signature), 32'h0);

        // Zero seed substitutes 0xACE1; first vector is its low five bits.
        do_run(16'h0000, 1, "t2", sig);

        // Constant-one response over three vectors.
        resp_mode = 1;
        do_run(16'h0001, 3, "t3", sig);
        check("t3 signature literal", 32'(bus.signature), 32'h0007);
        check("t3 done", 32'(bus.done), 32'h1);

        // Empty run goes straight to DONE.
        resp_mode       = 0;
        bus.seed        = 16'h1234;
        bus.num_vectors = '0;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t4 done", 32'(bus.done), 32'h1);
        check("t4 busy", 32'(bus.busy), 32'h0);
        check("t4 vec_valid", 32'(bus.vec_valid), 32'h0);
        check("t4 signature", 32'(bus.signature), 32'h0);
        tick();
        check("t4 vec_valid later", 32'(bus.vec_valid), 32'h0);

        // Randomized runs with a parity-function subcircuit and noise between responses.
        resp_mode = 2;
        for (int r = 0; r < 6; r++) begin
            resp_mask = 5'($urandom);
            resp_inv  = 1'($urandom);
            do_run(16'($urandom), int'($urandom_range(1, 40)), $sformatf("rand%0d", r), sig);
        end

        // Abort from DONE keeps the signature and drops done.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_done done", 32'(bus.done), 32'h0);
        check("abort_done signature", 32'(bus.signature), 32'(sig));

        // Start during RUN is ignored; abort after two vectors returns to IDLE.
        build_model(16'h5A5A, 10, vecs, dummy);
        bus.seed        = 16'h5A5A;
        bus.num_vectors = 16'd10;
        bus.start       = 1'b1;
        tick();
        check("t5 vec0", 32'(bus.vec_out), 32'(vecs[0]));
        bus.seed = 16'h0F0F;
        tick();
        bus.start = 1'b0;
        check("t5 vec1 after ignored start", 32'(bus.vec_out), 32'(vecs[1]));
        check("t5 busy", 32'(bus.busy), 32'h1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5 busy after abort", 32'(bus.busy), 32'h0);
        check("t5 done after abort", 32'(bus.done), 32'h0);
        check("t5 vec_valid after abort", 32'(bus.vec_valid), 32'h0);
        check("t5 vec_out held", 32'(bus.vec_out), 32'(vecs[1]));
        tick();
        check("t5 idle vec_valid", 32'(bus.vec_valid), 32'h0);

        // Reset in DRAIN with start asserted.
        bus.seed        = 16'h00FF;
        bus.num_vectors = 16'd4;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10 && bus.vec_valid === 1'b1; i++) tick();
        check("t6 in drain", 32'(bus.busy), 32'h1);
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        check_reset_outputs("t6");
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("t6 idle busy", 32'(bus.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
